// File: rtl/mac_stream_unit_if.sv
// Port bundle for mac_stream_unit: the activation FIFO read port and the
// dot-product result port. master = the MAC unit, slave = its environment.
interface mac_stream_unit_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
);
    // Result handshake: a transfer happens on a rising clock edge where
    // res_valid && res_ready; once raised, res_valid and res_data hold until then.
    logic              fifo_empty;
    logic              fifo_rd;
    logic [DATA_W-1:0] fifo_dout;
    logic [ACC_W-1:0]  res_data;
    logic              res_valid;
    logic              res_ready;

    modport master (
        input  fifo_empty, fifo_dout, res_ready,
        output fifo_rd, res_data, res_valid
    );

    modport slave (
        output fifo_empty, fifo_dout, res_ready,
        input  fifo_rd, res_data, res_valid
    );
endinterface

// File: rtl/mac_stream_unit.sv
// Streaming dot-product unit: pops VEC_LEN signed activations from a FIFO,
// multiplies each by a locally stored weight and presents the sum.
module mac_stream_unit #(
    parameter int DATA_W  = 16,
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 40,
    localparam int AW     = $clog2(VEC_LEN)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              w_we,
    input  logic [AW-1:0]     w_addr,
    input  logic [DATA_W-1:0] w_data,
    mac_stream_unit_if.master bus,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             idx_q, idx_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [ACC_W-1:0]          res_data_q, res_data_d;
    logic                      res_valid_q, res_valid_d;
    logic signed [DATA_W-1:0]  weight_q [VEC_LEN];
    logic signed [DATA_W-1:0]  weight_d [VEC_LEN];

    logic signed [DATA_W-1:0]   act;
    logic signed [DATA_W-1:0]   wt;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]           prod_ext;
    logic [ACC_W-1:0]           sum;

    // fifo_dout is only meaningful in CAPTURE, one cycle after the pop.
    always_comb begin
        act      = $signed(bus.fifo_dout);
        wt       = weight_q[idx_q];
        prod     = act * wt;
        prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        sum      = acc_q + prod_ext;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        weight_d    = weight_q;

        case (state_q)
            IDLE: begin
                // A write coinciding with start lands before the first capture.
                if (w_we) weight_d[w_addr] = w_data;
                if (start) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!bus.fifo_empty) state_d = CAPTURE;
            end
            CAPTURE: begin
                acc_d = sum;
                if (idx_q == AW'(VEC_LEN-1)) begin
                    res_data_d  = sum;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            for (int i = 0; i < VEC_LEN; i++) weight_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            weight_q    <= weight_d;
        end
    end

    assign bus.fifo_rd   = (state_q == FETCH) && !bus.fifo_empty;
    assign bus.res_data  = res_data_q;
    assign bus.res_valid = res_valid_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mac_stream_unit.sv
// Directed plus randomized bench for mac_stream_unit with a FIFO model and a
// dot-product reference computed from the weight/data lists.
module tb_mac_stream_unit;

  localparam int DATA_W  = 16;
  localparam int VEC_LEN = 8;
  localparam int ACC_W   = 40;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              w_we;
  logic [2:0]        w_addr;
  logic [DATA_W-1:0] w_data;
  logic              busy;
  logic [1:0]        dbg_state;

  mac_stream_unit_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  mac_stream_unit #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .ACC_W(ACC_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int rd_viol = 0;
  int stall_left = 0;
  int stall_at_pop = 0;

  logic [DATA_W-1:0]        fifo_q[$];
  logic [ACC_W-1:0]         exp_q[$];
  logic signed [DATA_W-1:0] wm [VEC_LEN];
  logic signed [DATA_W-1:0] vec [VEC_LEN];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: pops the FIFO model on a strobe, presents data after the edge.
  task automatic tick();
    logic [DATA_W-1:0] v;
    logic got;
    v = '0;
    got = 1'b0;
    @(negedge clock);
    if (bus.fifo_rd === 1'b1) begin
      if (bus.fifo_empty || fifo_q.size() == 0) rd_viol++;
      else begin
        v = fifo_q.pop_front();
        got = 1'b1;
        pops++;
      end
    end
    @(posedge clock);
    #1;
    if (got) bus.fifo_dout = v;
    if (stall_left > 0) stall_left--;
    if (got && pops == stall_at_pop) stall_left = 5;
    bus.fifo_empty = (fifo_q.size() == 0) || (stall_left > 0);
  endtask

  task automatic write_weight(input int addr, input logic signed [DATA_W-1:0] val);
    w_we = 1'b1;
    w_addr = 3'(addr);
    w_data = val;
    tick();
    w_we = 1'b0;
    wm[addr] = val;
  endtask

  task automatic write_all(input logic signed [DATA_W-1:0] val);
    for (int i = 0; i < VEC_LEN; i++) write_weight(i, val);
  endtask

  task automatic fill_vec(input logic signed [DATA_W-1:0] val);
    for (int i = 0; i < VEC_LEN; i++) vec[i] = val;
  endtask

  task automatic ramp_vec();
    for (int i = 0; i < VEC_LEN; i++) vec[i] = DATA_W'(i + 1);
  endtask

  // Runs one vector from vec[] against the model weights wm[].
  task automatic run_vector(input string tag, input int ready_delay,
                            input bit check_lat, input bit done_pokes);
    longint s;
    logic [ACC_W-1:0] e;
    int cyc;
    s = 0;
    for (int i = 0; i < VEC_LEN; i++) begin
      fifo_q.push_back(vec[i]);
      s += longint'(vec[i]) * longint'(wm[i]);
    end
    exp_q.push_back(s[ACC_W-1:0]);
    pops = 0;
    bus.fifo_empty = (fifo_q.size() == 0) || (stall_left > 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    w_we = 1'b0;
    cyc = 0;
    while (bus.res_valid !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    chk({tag, "_valid_seen"}, 64'(bus.res_valid), 64'd1);
    if (check_lat) chk({tag, "_latency"}, 64'(cyc), 64'd16);
    chk({tag, "_pops"}, 64'(pops), 64'd8);
    e = exp_q.pop_front();
    chk({tag, "_res_data"}, 64'(bus.res_data), 64'(e));
    for (int k = 0; k < ready_delay; k++) begin
      if (done_pokes && k == 0) begin
        start = 1'b1;
        w_we = 1'b1;
        w_addr = 3'd0;
        w_data = ~wm[0];
      end
      tick();
      start = 1'b0;
      w_we = 1'b0;
      chk({tag, "_hold_valid"}, 64'(bus.res_valid), 64'd1);
      chk({tag, "_hold_data"}, 64'(bus.res_data), 64'(e));
      if (done_pokes) chk({tag, "_hold_state"}, 64'(dbg_state), 64'd3);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_valid_after"}, 64'(bus.res_valid), 64'd0);
    chk({tag, "_data_kept"}, 64'(bus.res_data), 64'(e));
    chk({tag, "_pops_after"}, 64'(pops), 64'd8);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    start = 1'b0;
    w_we = 1'b0;
    w_addr = '0;
    w_data = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < VEC_LEN; i++) wm[i] = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_data", 64'(bus.res_data), 64'd0);
    chk("rst_rd", 64'(bus.fifo_rd), 64'd0);

    write_all(16'sd1);
    ramp_vec();
    run_vector("unit_ramp", 0, 1'b1, 1'b0);

    write_all(-16'sd2);
    fill_vec(16'sd3);
    run_vector("neg_two", 0, 1'b1, 1'b0);

    write_all(-16'sd32768);
    fill_vec(-16'sd32768);
    run_vector("max_neg", 0, 1'b1, 1'b0);

    write_all(16'sd1);
    ramp_vec();
    stall_at_pop = 3;
    run_vector("stall", 0, 1'b0, 1'b0);
    stall_at_pop = 0;

    run_vector("done_hold", 5, 1'b1, 1'b1);
    run_vector("w_we_ignored", 0, 1'b1, 1'b0);

    // Write and start in the same cycle: the vector sees the new weight.
    w_we = 1'b1;
    w_addr = 3'd3;
    w_data = 16'sd7;
    wm[3] = 16'sd7;
    run_vector("write_with_start", 0, 1'b1, 1'b0);

    ramp_vec();
    for (int i = 0; i < VEC_LEN; i++) fifo_q.push_back(vec[i]);
    pops = 0;
    bus.fifo_empty = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (pops < 4 && guard < 100) begin
      tick();
      guard++;
    end
    chk("mid_pops_reached", 64'(pops), 64'd4);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    chk("mid_rst_valid", 64'(bus.res_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    fifo_q.delete();
    bus.fifo_empty = 1'b1;
    for (int i = 0; i < VEC_LEN; i++) wm[i] = '0;
    ramp_vec();
    run_vector("zero_weights", 0, 1'b1, 1'b0);

    for (int i = 0; i < VEC_LEN; i++) write_weight(i, DATA_W'(i + 1));
    fill_vec(16'sd1);
    run_vector("ramp_weights", 0, 1'b1, 1'b0);
    write_weight(7, 16'sd0);
    run_vector("ramp_w7_zero", 0, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < VEC_LEN; i++) write_weight(i, DATA_W'($urandom));
      for (int i = 0; i < VEC_LEN; i++) vec[i] = DATA_W'($urandom);
      run_vector($sformatf("rand%0d", r), $urandom_range(0, 3), 1'b1, 1'b0);
    end

    chk("fifo_rd_while_empty", 64'(rd_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_stream_unit.md
Name: mac_stream_unit

Overview:
- Downstream consumer of the 16-bit activation FIFO in the accelerator datapath.
- Pops VEC_LEN signed activations from the FIFO read port.
- Multiplies each activation by a locally stored signed weight and accumulates the products into one dot-product result.
- Presents the result on a valid/ready output to the next stage.

Parameters:
DATA_W, 16, activation/weight width (signed two's complement)
VEC_LEN, 8, elements per dot product; must be a power of 2 and ≥ 2
ACC_W, 40, accumulator/result width; must be ≥ 2*DATA_W + log2(VEC_LEN)

Ports:
clock  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-high
start  in  1  begin one dot product; honoured only in IDLE
w_we  in  1  weight write enable; honoured only in IDLE
w_addr  in  log2(VEC_LEN)  weight index
w_data  in  DATA_W  signed weight value
fifo_empty  in  1  upstream FIFO empty flag
fifo_rd  out  1  FIFO read strobe (one pop per cycle asserted)
fifo_dout  in  DATA_W  FIFO read data; valid the cycle after fifo_rd
res_data  out  ACC_W  signed dot-product result
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous): state=IDLE, all weights=0, acc=0, idx=0, res_data=0, res_valid=0, busy=0, fifo_rd=0. Reset overrides every other input in the same cycle.
- Reset mid-operation: the vector is abandoned and the partial acc is discarded. Any element already popped is lost; the FIFO is not rewound.
- Weight RAM: VEC_LEN x DATA_W registers.
  - Write takes effect at the clock edge when w_we=1 and state=IDLE.
  - w_we is ignored in any other state.
  - Weights persist across vectors until rewritten or reset.
- FSM states: IDLE, FETCH, CAPTURE, DONE.
  - IDLE: start=1 -> acc<=0, idx<=0, go FETCH. If w_we and start are both high, the write completes and the vector uses the new weight.
  - FETCH: fifo_rd = !fifo_empty (combinational). If fifo_empty=0, go CAPTURE; otherwise stay in FETCH indefinitely (stall, fifo_rd=0).
  - CAPTURE: acc <= acc + sext(fifo_dout * weight[idx]), with a full-precision signed 2*DATA_W product sign-extended to ACC_W.
    - If idx==VEC_LEN-1: res_data <= acc + product, res_valid <= 1, go DONE.
    - Otherwise: idx <= idx+1, go FETCH.
  - DONE: hold res_valid=1 and res_data stable until res_ready=1. On the handshake cycle: res_valid <= 0, go IDLE.
- fifo_rd is never asserted outside FETCH and never while fifo_empty=1. Exactly VEC_LEN pops occur per vector.
- Throughput: 2 cycles per element when the FIFO is non-empty. The earliest res_valid comes 2*VEC_LEN cycles after the start edge (16 for defaults).
- start while busy=1 is ignored; nothing is queued.
- res_data retains the last result after the handshake until the next result or reset.
- No saturation. ACC_W guarantees no overflow; worst case (-32768 * -32768 * 8 = 2^33) fits in 40 bits.
- busy is combinational from state.

Test Plan:
- Reset, write weights all 1, FIFO preloaded with 1..8, start, res_ready=1 -> exactly 8 fifo_rd pulses; res_valid 16 cycles after start; res_data=36; busy low the cycle after the handshake.
- Weights all -2 (0xFFFE), data all 3 -> res_data=-48 (sign-extended, 40'hFF_FFFF_FFD0). Weights all -32768, data all -32768 -> res_data=8589934592.
- FIFO empty for 5 cycles after the 3rd pop, then refilled, data 1..8 with unit weights -> fifo_rd stays 0 while empty; no extra accumulation; res_data=36.
- Result ready, res_ready held low 5 cycles -> res_valid and res_data stable throughout. start pulsed during DONE -> ignored. w_we during DONE -> weight unchanged.
- Reset asserted after the 4th pop -> next cycle state=IDLE, res_valid=0, weights=0. A new start with data 1..8 and zero weights -> res_data=0.
- Weights 1..8 written at indices 0..7, data all 1 -> res_data=36. Rewrite index 7 with 0 in IDLE and run again -> res_data=28.
